// File: rtl/count_check_pkg.sv
`default_nettype none
// ============================================================================
// Module   : count_check_pkg
// Purpose  : Shared FSM encoding and counter widths for the count stream checker.
// Revision : 1.0
// ============================================================================
package count_check_pkg;

    localparam int c_cnt_width = 4;

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Saturating up-counter; a clear coincident with an increment yields 1.
// Revision : 1.0
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? WIDTH'(1) : '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/count_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : count_stream_checker
// Purpose  : Locks onto an incrementing count stream, flywheels the expected
//            value and tallies out-of-sequence samples while locked.
// Revision : 1.0
// ============================================================================
module count_stream_checker
    import count_check_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 2,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 err_clr,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic [WIDTH-1:0]     expected
);

    localparam logic [c_cnt_width-1:0] c_lock = c_cnt_width'(LOCK_COUNT);
    localparam logic [c_cnt_width-1:0] c_loss = c_cnt_width'(LOSS_COUNT);
    localparam logic [c_cnt_width-1:0] c_one  = c_cnt_width'(1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_cnt_width-1:0] r_run;
    logic [c_cnt_width-1:0] r_miss;
    logic [c_cnt_width-1:0] w_run_nxt;
    logic [c_cnt_width-1:0] w_miss_nxt;
    logic [WIDTH-1:0]       w_exp_nxt;
    logic                   w_err_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_HUNT;
            r_run     <= '0;
            r_miss    <= '0;
            expected  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_run     <= w_run_nxt;
            r_miss    <= w_miss_nxt;
            expected  <= w_exp_nxt;
            locked    <= (w_state_nxt == ST_LOCKED);
            err_pulse <= w_err_hit;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_miss_nxt  = r_miss;
        w_exp_nxt   = expected;
        w_err_hit   = 1'b0;
        if (din_valid) begin
            case (r_state)
                ST_HUNT: begin
                    // Any sample that breaks the run simply becomes the new seed.
                    w_exp_nxt = din + 1'b1;
                    if ((r_run == '0) || (din != expected)) begin
                        w_run_nxt = c_one;
                    end else begin
                        w_run_nxt = r_run + 1'b1;
                        if (w_run_nxt == c_lock) begin
                            w_state_nxt = ST_LOCKED;
                            w_miss_nxt  = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: expected advances regardless of what arrived.
                    w_exp_nxt = expected + 1'b1;
                    if (din == expected) begin
                        w_miss_nxt = '0;
                    end else begin
                        w_err_hit  = 1'b1;
                        w_miss_nxt = r_miss + 1'b1;
                        if (w_miss_nxt == c_loss) begin
                            w_state_nxt = ST_HUNT;
                            w_run_nxt   = '0;
                        end
                    end
                end
                default: w_state_nxt = ST_HUNT;
            endcase
        end
    end

    sat_counter #(
        .WIDTH (ERR_WIDTH)
    ) u_err_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_err_hit),
        .clr   (err_clr),
        .count (err_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_count_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_stream_checker
// Purpose  : Scoreboard bench for count_stream_checker (ERR_WIDTH=2).
// Revision : 1.0
// ============================================================================
module tb_count_stream_checker;

    localparam int WIDTH = 8;
    localparam int LOCK  = 4;
    localparam int LOSS  = 2;
    localparam int EW    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic             err_clr = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic [EW-1:0]    err_count;
    logic [WIDTH-1:0] expected;

    count_stream_checker #(
        .WIDTH      (WIDTH),
        .LOCK_COUNT (LOCK),
        .LOSS_COUNT (LOSS),
        .ERR_WIDTH  (EW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .err_clr   (err_clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .expected  (expected)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             lk;
        logic             pulse;
        logic [EW-1:0]    cnt;
        logic [WIDTH-1:0] ex;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pulses = 0;

    // Reference model state, derived from the behavioural description.
    logic             m_lk = 1'b0;
    logic [WIDTH-1:0] m_exp = '0;
    int               m_run = 0;
    int               m_miss = 0;
    int               m_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model(input logic r, input logic v, input logic [WIDTH-1:0] d,
                         input logic c, output exp_t e);
        logic hit;
        hit = 1'b0;
        if (r) begin
            m_lk = 1'b0; m_exp = '0; m_run = 0; m_miss = 0; m_cnt = 0;
        end else begin
            if (v) begin
                if (!m_lk) begin
                    if (m_run == 0 || d != m_exp) m_run = 1;
                    else begin
                        m_run++;
                        if (m_run == LOCK) begin m_lk = 1'b1; m_miss = 0; end
                    end
                    m_exp = d + 8'd1;
                end else begin
                    if (d == m_exp) m_miss = 0;
                    else begin
                        hit = 1'b1;
                        m_miss++;
                        if (m_miss == LOSS) begin m_lk = 1'b0; m_run = 0; end
                    end
                    m_exp = m_exp + 8'd1;
                end
            end
            if (c) m_cnt = hit ? 1 : 0;
            else if (hit && m_cnt < (1 << EW) - 1) m_cnt++;
        end
        e.lk = m_lk; e.pulse = hit; e.cnt = EW'(m_cnt); e.ex = m_exp;
    endtask

    task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] d, input logic c);
        exp_t e;
        exp_t got;
        rst = r; din_valid = v; din = d; err_clr = c;
        model(r, v, d, c, e);
        q.push_back(e);
        @(posedge clk);
        #1;
        got = q.pop_front();
        if (err_pulse === 1'b1) n_pulses++;
        check("locked", 32'(locked), 32'(got.lk));
        check("err_pulse", 32'(err_pulse), 32'(got.pulse));
        check("err_count", 32'(err_count), 32'(got.cnt));
        check("expected", 32'(expected), 32'(got.ex));
    endtask

    task automatic feed(input logic [WIDTH-1:0] d);
        step(1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        // Reset
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_expected", 32'(expected), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);

        // Lock on 10..13
        n_pulses = 0;
        feed(8'd10); feed(8'd11); feed(8'd12);
        check("prelock", 32'(locked), 32'd0);
        feed(8'd13);
        check("lock_locked", 32'(locked), 32'd1);
        check("lock_expected", 32'(expected), 32'd14);
        check("lock_pulses", 32'(n_pulses), 32'd0);

        // Wrap through FF -> 00
        step(1'b1, 1'b0, 8'h00, 1'b0);
        feed(8'hFA); feed(8'hFB); feed(8'hFC); feed(8'hFD);
        n_pulses = 0;
        feed(8'hFE); feed(8'hFF); feed(8'h00); feed(8'h01);
        check("wrap_locked", 32'(locked), 32'd1);
        check("wrap_expected", 32'(expected), 32'h02);
        check("wrap_pulses", 32'(n_pulses), 32'd0);

        // Single glitch
        step(1'b1, 1'b0, 8'h00, 1'b0);
        feed(8'd16); feed(8'd17); feed(8'd18); feed(8'd19);
        n_pulses = 0;
        feed(8'd20); feed(8'd99);
        check("glitch_pulse", 32'(err_pulse), 32'd1);
        feed(8'd22); feed(8'd23);
        check("glitch_pulses", 32'(n_pulses), 32'd1);
        check("glitch_count", 32'(err_count), 32'd1);
        check("glitch_locked", 32'(locked), 32'd1);
        check("glitch_expected", 32'(expected), 32'd24);

        // err_clr alone
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("clr_alone", 32'(err_count), 32'd0);

        // Loss and relock
        for (int i = 24; i < 30; i++) feed(8'(i));
        check("loss_pre_exp", 32'(expected), 32'd30);
        n_pulses = 0;
        feed(8'd99);
        check("loss_still_locked", 32'(locked), 32'd1);
        feed(8'd98);
        check("loss_unlocked", 32'(locked), 32'd0);
        check("loss_pulses", 32'(n_pulses), 32'd2);
        check("loss_count", 32'(err_count), 32'd2);
        feed(8'd5); feed(8'd6); feed(8'd7); feed(8'd8);
        check("relock", 32'(locked), 32'd1);
        check("relock_expected", 32'(expected), 32'd9);

        // Gaps and hunt restart
        step(1'b1, 1'b0, 8'h00, 1'b0);
        n_pulses = 0;
        feed(8'd10); idle(); feed(8'd11); idle();
        feed(8'd50); idle(); feed(8'd51); idle(); feed(8'd52); idle();
        check("gap_prelock", 32'(locked), 32'd0);
        feed(8'd53);
        check("gap_locked", 32'(locked), 32'd1);
        check("gap_pulses", 32'(n_pulses), 32'd0);
        idle();
        check("gap_hold_exp", 32'(expected), 32'd54);

        // Reset mid-lock with a nonzero tally
        feed(8'd0);
        check("midrst_pre_count", 32'(err_count), 32'd1);
        step(1'b1, 1'b1, 8'd55, 1'b0);
        check("midrst_locked", 32'(locked), 32'd0);
        check("midrst_count", 32'(err_count), 32'd0);

        // Saturation with isolated mismatches
        step(1'b0, 1'b0, 8'h00, 1'b0);
        feed(8'd100); feed(8'd101); feed(8'd102); feed(8'd103);
        n_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            feed(8'(154 + 2 * i));
            feed(8'(105 + 2 * i));
        end
        check("sat_count", 32'(err_count), 32'd3);
        check("sat_pulses", 32'(n_pulses), 32'd5);
        check("sat_locked", 32'(locked), 32'd1);

        // err_clr coincident with a mismatch, then alone
        step(1'b0, 1'b1, 8'd0, 1'b1);
        check("clr_hit_count", 32'(err_count), 32'd1);
        step(1'b0, 1'b0, 8'd0, 1'b1);
        check("clr_final", 32'(err_count), 32'd0);
        check("clr_locked", 32'(locked), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_stream_checker.md
Name: count_stream_checker

Overview:
- Receive-side counterpart to the team's free-running 8-bit counter. Samples a count stream, for example the counter's outputs looped back into another design's inputs.
- Locks onto an incrementing sequence and flywheels the expected value.
- Flags every out-of-sequence sample and keeps a saturating error tally.
- Used as an on-chip self-test for counter/loopback paths.

Parameters:
WIDTH, 8, width of sampled count and expected value
LOCK_COUNT, 4, consecutive in-sequence samples (seed included) needed to declare lock; legal range 2..15
LOSS_COUNT, 2, consecutive mismatches while locked that drop lock; legal range 1..15
ERR_WIDTH, 8, width of saturating error counter

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  synchronous reset, active-high
din  in  WIDTH  sampled count value
din_valid  in  1  din is meaningful this cycle; samples with din_valid=0 are ignored entirely
err_clr  in  1  synchronous clear of err_count
locked  out  1  high while the FSM is in LOCKED
err_pulse  out  1  one-cycle pulse per mismatching sample while locked
err_count  out  ERR_WIDTH  saturating count of mismatches seen while locked
expected  out  WIDTH  next value the checker expects

Behaviour:
- Reset is synchronous, active-high, and overrides every other input.
  - On reset: state=HUNT, locked=0, err_pulse=0, err_count=0, expected=0, run=0, miss=0.
  - Reset asserted mid-operation has the same effect: lock is lost and err_count is cleared.
- All outputs are registered. A response appears the cycle after the din_valid sample that causes it.
- Arithmetic is modulo 2^WIDTH, so 'hFF is followed by 'h00 with no error for WIDTH=8.
- "Match" means din == expected.
- HUNT state:
  - Valid sample with run=0: expected<=din+1, run<=1. This is the seed sample.
  - Valid match with run>0: expected<=din+1, run<=run+1. When run+1==LOCK_COUNT, go to LOCKED, set locked=1, miss<=0.
  - Valid mismatch with run>0: treat din as a new seed. expected<=din+1, run<=1. No err_pulse and no count change in HUNT.
- LOCKED state:
  - Valid match: expected<=expected+1, miss<=0.
  - Valid mismatch: err_pulse=1, err_count increments (saturating at all-ones), expected<=expected+1 (flywheel, no resync to din), miss<=miss+1.
  - When miss+1==LOSS_COUNT: go to HUNT, locked=0, run<=0. The next valid sample is the new seed.
- din_valid=0 leaves state, expected, run and miss unchanged, and err_pulse=0.
- err_clr:
  - err_clr=1 sets err_count to 0.
  - If a mismatch error occurs in the same cycle, err_count becomes 1; the error is never lost.
  - err_clr does not affect the FSM or locked.
- Saturation: once err_count is all-ones it holds, while err_pulse still fires on each mismatch.
- run and miss are 4 bits; they never exceed their thresholds.

Decomposition:
- Package count_check_pkg holds:
  - state enum {HUNT, LOCKED}, 1-bit encoding;
  - localparams for the run/miss counter width (4).
- One natural sub-module: sat_counter (parameter width, inputs inc and clr, clr+inc gives 1, holds at max). It implements err_count.
- The FSM, expected register and run/miss counters stay in the top.

Test Plan:
- Lock: after reset, drive valid 10,11,12,13 on consecutive cycles -> locked rises the cycle after 13. Then expected=14, err_pulse never high, err_count=0.
- Wrap: once locked, drive 'hFE,'hFF,'h00,'h01 in sequence -> locked stays 1, no err_pulse, expected='h02 at the end.
- Single glitch: locked with expected=20, drive 20,99,22,23 -> exactly one err_pulse, the cycle after 99. err_count=1, locked stays 1, expected=24 at the end.
- Loss and relock: locked with expected=30, drive 99,98 (LOSS_COUNT=2) -> two err_pulses, locked falls after 98, err_count=2. Then drive 5,6,7,8 -> relock after 8 with expected=9.
- Gaps and hunt restarts:
  - In HUNT, drive 10,11,50,51,52,53 with din_valid low on alternate cycles -> locked only after 53, no err_pulse, gaps ignored.
  - Reset asserted mid-lock -> locked=0 and err_count=0 the next cycle.
- Saturation and clear:
  - With ERR_WIDTH=2, force 5 isolated mismatches while locked -> err_count holds at 3, 5 err_pulses.
  - err_clr coincident with a mismatch -> err_count=1.
  - err_clr alone -> err_count=0.
